// File: rtl/sdram_init_checker_pkg.sv
// Shared definitions for the SDRAM power-up checker.
// Holds the {cs,ras,cas,we} command encodings, the error codes reported on
// err_code, the mode-register field positions and the mode validity rule.
package sdram_init_checker_pkg;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MSET = 4'b0000;

  localparam int ADDR_A10 = 10;
  localparam int MR_CL_HI = 6;
  localparam int MR_CL_LO = 4;
  localparam int MR_BL_HI = 2;
  localparam int MR_BL_LO = 0;

  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_EARLY  = 3'd1,
    ERR_ORDER  = 3'd2,
    ERR_A10    = 3'd3,
    ERR_MODE   = 3'd4,
    ERR_TIMING = 3'd5
  } err_e;

  typedef enum logic [2:0] {
    S_WAIT_PWR,
    S_WAIT_AREF,
    S_WAIT_MSET,
    S_WAIT_MRD,
    S_READY,
    S_ERROR
  } state_e;

  // Reserved bits zero, CAS latency 2 or 3, burst length code 0..3.
  function automatic logic mode_ok(input logic [12:0] a);
    return (a[12:10] == 3'b000) && (a[8:7] == 2'b00) &&
           (a[MR_CL_HI:MR_CL_LO] == 3'd2 || a[MR_CL_HI:MR_CL_LO] == 3'd3) &&
           (a[MR_BL_HI] == 1'b0);
  endfunction

endpackage

// File: rtl/sdram_init_checker_if.sv
// Command/address bus between the init controller (master) and the
// checker sitting beside the SDRAM pins (slave).
//   cmd        : {cs,ras,cas,we}
//   sdram_addr : 13-bit address, sampled with cmd
interface sdram_init_checker_if;
  logic [3:0]  cmd;
  logic [12:0] sdram_addr;

  modport master (output cmd, output sdram_addr);
  modport slave  (input  cmd, input  sdram_addr);
endinterface

// File: rtl/sdram_init_checker_gap_timer.sv
// Command spacing timer.
// gap_cnt is 1 on the cycle after a non-NOP command and counts up
// (saturating at 255) until the next one. The required gap depends on the
// previous command: T_RFC after AREF, T_RP otherwise.
//   sclk, s_rst : clock, synchronous active-high reset
//   cmd_vld     : non-NOP command this cycle (restarts the count)
//   cmd_aref    : that command is AREF
//   gap_ok      : current command is far enough from the previous one
module sdram_gap_timer #(
  parameter int T_RP  = 1,
  parameter int T_RFC = 4
) (
  input  logic sclk,
  input  logic s_rst,
  input  logic cmd_vld,
  input  logic cmd_aref,
  output logic gap_ok
);

  localparam logic [7:0] RP8  = 8'(T_RP);
  localparam logic [7:0] RFC8 = 8'(T_RFC);

  logic [7:0] gap_cnt;
  logic       last_aref;

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      gap_cnt   <= '0;
      last_aref <= 1'b0;
    end else if (cmd_vld) begin
      gap_cnt   <= 8'd1;
      last_aref <= cmd_aref;
    end else if (gap_cnt != 8'hFF) begin
      gap_cnt   <= gap_cnt + 8'd1;
    end
  end

  assign gap_ok = last_aref ? (gap_cnt >= RFC8) : (gap_cnt >= RP8);

endmodule

// File: rtl/sdram_init_checker.sv
// Device-side responder for the SDRAM power-up sequence.
// Decodes the command bus, checks order and spacing of PRE/AREF/MSET,
// latches the programmed mode register and reports init_done or a sticky
// error with the code of the first violation.
//   sclk, s_rst : clock, synchronous active-high reset
//   bus         : slave side of the cmd/sdram_addr bus
//   init_done   : legal sequence complete (sticky until reset)
//   init_err    : violation seen (sticky until reset)
//   err_code    : first violation code (err_e)
//   mode_reg    : last legal MSET address; cas_lat/burst_len are its fields
//   aref_cnt    : AREFs accepted in READY, saturating
module sdram_init_checker
  import sdram_init_checker_pkg::*;
#(
  parameter int DELAY_PWR = 10000,
  parameter int T_RP      = 1,
  parameter int T_RFC     = 4,
  parameter int T_MRD     = 2,
  parameter int N_AREF    = 2
) (
  input  logic                  sclk,
  input  logic                  s_rst,
  sdram_init_checker_if.slave   bus,
  output logic                  init_done,
  output logic                  init_err,
  output logic [2:0]            err_code,
  output logic [12:0]           mode_reg,
  output logic [2:0]            cas_lat,
  output logic [2:0]            burst_len,
  output logic [15:0]           aref_cnt
);

  localparam int             PW       = $clog2(DELAY_PWR + 1);
  localparam logic [PW-1:0]  PWR_MAX  = PW'(DELAY_PWR);
  localparam logic [7:0]     NAREF8   = 8'(N_AREF);
  localparam logic [7:0]     MRD_LAST = 8'(T_MRD - 1);

  state_e        state, state_nxt;
  err_e          err_nxt;
  logic [PW-1:0] pwr_cnt;
  logic [7:0]    aref_seen, mrd_cnt;
  logic          mode_ld, aref_inc, seen_inc;
  logic          is_nop, is_pre, is_aref, is_mset, gap_ok, pwr_done;

  // Deselect (cs=1) is a NOP regardless of the other bits.
  assign is_nop   = bus.cmd[3] || (bus.cmd == CMD_NOP);
  assign is_pre   = (bus.cmd == CMD_PRE);
  assign is_aref  = (bus.cmd == CMD_AREF);
  assign is_mset  = (bus.cmd == CMD_MSET);
  assign pwr_done = (pwr_cnt == PWR_MAX);

  sdram_gap_timer #(.T_RP(T_RP), .T_RFC(T_RFC)) u_gap (
    .sclk     (sclk),
    .s_rst    (s_rst),
    .cmd_vld  (!is_nop),
    .cmd_aref (is_aref),
    .gap_ok   (gap_ok)
  );

  always_comb begin
    state_nxt = state;
    err_nxt   = ERR_NONE;
    mode_ld   = 1'b0;
    aref_inc  = 1'b0;
    seen_inc  = 1'b0;
    // init_done rises T_MRD edges after the MSET edge, unless a command
    // lands in the window (handled below as TIMING).
    if (state == S_WAIT_MRD && is_nop && mrd_cnt == MRD_LAST)
      state_nxt = S_READY;
    if (!is_nop && state != S_ERROR) begin
      // Priority chain: EARLY > A10 > MODE > per-state ORDER/TIMING.
      if (state == S_WAIT_PWR && !pwr_done)
        err_nxt = ERR_EARLY;
      else if (is_pre && !bus.sdram_addr[ADDR_A10])
        err_nxt = ERR_A10;
      else if (is_mset && !mode_ok(bus.sdram_addr))
        err_nxt = ERR_MODE;
      else begin
        case (state)
          S_WAIT_PWR: begin
            if (is_pre) state_nxt = S_WAIT_AREF;
            else        err_nxt   = ERR_ORDER;
          end
          S_WAIT_AREF: begin
            if (is_aref) begin
              if (!gap_ok) err_nxt = ERR_TIMING;
              else begin
                seen_inc = 1'b1;
                if (aref_seen + 8'd1 >= NAREF8) state_nxt = S_WAIT_MSET;
              end
            end else if (!is_pre) begin
              err_nxt = ERR_ORDER;
            end
          end
          S_WAIT_MSET: begin
            if (is_aref) begin
              if (!gap_ok) err_nxt = ERR_TIMING;
            end else if (is_mset) begin
              if (!gap_ok) err_nxt = ERR_TIMING;
              else begin
                mode_ld   = 1'b1;
                state_nxt = S_WAIT_MRD;
              end
            end else begin
              err_nxt = ERR_ORDER;
            end
          end
          S_WAIT_MRD: err_nxt = ERR_TIMING;
          S_READY: begin
            if (is_aref)      aref_inc = 1'b1;
            else if (is_mset) mode_ld  = 1'b1;
          end
          default: ;
        endcase
      end
      if (err_nxt != ERR_NONE) state_nxt = S_ERROR;
    end
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state     <= S_WAIT_PWR;
      pwr_cnt   <= '0;
      aref_seen <= '0;
      mrd_cnt   <= '0;
      mode_reg  <= '0;
      aref_cnt  <= '0;
      err_code  <= '0;
    end else begin
      state   <= state_nxt;
      if (!pwr_done) pwr_cnt <= pwr_cnt + 1'b1;
      if (seen_inc)  aref_seen <= aref_seen + 8'd1;
      mrd_cnt <= (state == S_WAIT_MRD) ? mrd_cnt + 8'd1 : 8'd0;
      if (mode_ld) mode_reg <= bus.sdram_addr;
      if (aref_inc && aref_cnt != 16'hFFFF) aref_cnt <= aref_cnt + 16'd1;
      // Only the first violation is recorded; ERROR is absorbing.
      if (state_nxt == S_ERROR && state != S_ERROR) err_code <= err_nxt;
    end
  end

  assign init_done = (state == S_READY);
  assign init_err  = (state == S_ERROR);
  assign cas_lat   = mode_reg[MR_CL_HI:MR_CL_LO];
  assign burst_len = mode_reg[MR_BL_HI:MR_BL_LO];

endmodule
